// File: rtl/fir_pkg.sv
// Shared constants and rounding/saturation helpers for the fir_filter family.
// Helpers work at a wide internal width, so callers only narrow the final result.
package fir_pkg;

    localparam int FIR_DATA_WIDTH  = 8;
    localparam int FIR_COEFF_WIDTH = 8;
    localparam int FIR_TAPS        = 8;
    localparam int FIR_IN_WIDTH    = FIR_DATA_WIDTH + FIR_COEFF_WIDTH + 2;
    localparam int CALC_WIDTH      = 64;

    function automatic logic signed [CALC_WIDTH-1:0] fir_max(input int out_width);
        return (CALC_WIDTH'(1) <<< (out_width - 1)) - CALC_WIDTH'(1);
    endfunction

    function automatic logic signed [CALC_WIDTH-1:0] fir_min(input int out_width);
        return -(CALC_WIDTH'(1) <<< (out_width - 1));
    endfunction

    // Round half toward +inf; the wide add cannot wrap for any legal input width.
    function automatic logic signed [CALC_WIDTH-1:0] fir_round(
        input logic signed [CALC_WIDTH-1:0] y,
        input int                           shift
    );
        logic signed [CALC_WIDTH-1:0] half;
        half = CALC_WIDTH'(1) <<< (shift - 1);
        return (y + half) >>> shift;
    endfunction

    function automatic logic fir_is_clipped(
        input logic signed [CALC_WIDTH-1:0] y,
        input int                           shift,
        input int                           out_width
    );
        logic signed [CALC_WIDTH-1:0] t;
        t = fir_round(y, shift);
        return (t > fir_max(out_width)) || (t < fir_min(out_width));
    endfunction

    function automatic logic signed [CALC_WIDTH-1:0] fir_round_sat(
        input logic signed [CALC_WIDTH-1:0] y,
        input int                           shift,
        input int                           out_width
    );
        logic signed [CALC_WIDTH-1:0] t;
        t = fir_round(y, shift);
        if (t > fir_max(out_width)) begin
            t = fir_max(out_width);
        end else if (t < fir_min(out_width)) begin
            t = fir_min(out_width);
        end
        return t;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module fir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is forced to zero while empty so stale or uninitialised memory never shows.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/fir_out_buffer.sv
// Output stage of fir_filter: round/saturate the wide result to sample width,
// then buffer it in a FWFT FIFO drained with valid/ready.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
    parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter int IN_WIDTH    = DATA_WIDTH + COEFF_WIDTH + 2,
    parameter int SHIFT       = 7,
    parameter int DEPTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [IN_WIDTH-1:0]   y_in,
    input  logic                         y_valid,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         sat_flag,
    output logic                         overflow,
    input  logic                         clr_ovf,
    output logic [$clog2(DEPTH):0]       count
);

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  sat_q, sat_d;
    logic                  ovf_q, ovf_d;
    logic                  fifo_full, fifo_empty;
    logic                  m_pop, drop;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    always_comb begin
        s1_valid_d = y_valid;
        s1_data_d  = s1_data_q;
        sat_d      = 1'b0;
        if (y_valid) begin
            s1_data_d = DATA_WIDTH'(fir_round_sat(CALC_WIDTH'(y_in), SHIFT, DATA_WIDTH));
            sat_d     = fir_is_clipped(CALC_WIDTH'(y_in), SHIFT, DATA_WIDTH);
        end
    end

    // A fresh drop takes priority over a clear requested in the same cycle.
    always_comb begin
        m_pop = ~fifo_empty & m_ready;
        drop  = s1_valid_q & fifo_full & ~m_pop;
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s1_valid_q),
        .pop     (m_pop),
        .wr_data (s1_data_q),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign m_data   = fifo_rd_data;
    assign m_valid  = ~fifo_empty;
    assign sat_flag = sat_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Randomised and directed bench for fir_out_buffer against a queue-based model
// that rounds with integer division and tracks the FIFO as a plain list.
module tb_fir_out_buffer;

    localparam int DATA_WIDTH  = 8;
    localparam int COEFF_WIDTH = 8;
    localparam int IN_WIDTH    = DATA_WIDTH + COEFF_WIDTH + 2;
    localparam int SHIFT       = 7;
    localparam int DEPTH       = 8;
    localparam int HALF        = 1 << (SHIFT - 1);
    localparam int SCALE       = 1 << SHIFT;
    localparam int MAX_OUT     = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int MIN_OUT     = -(1 << (DATA_WIDTH - 1));

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic signed [IN_WIDTH-1:0]   y_in = '0;
    logic                         y_valid = 1'b0;
    logic                         m_ready = 1'b0;
    logic                         clr_ovf = 1'b0;
    logic signed [DATA_WIDTH-1:0] m_data;
    logic                         m_valid;
    logic                         sat_flag;
    logic                         overflow;
    logic [$clog2(DEPTH):0]       count;

    int total = 0;
    int bad   = 0;

    int model_fifo[$];
    bit model_s1_valid = 1'b0;
    int model_s1_val   = 0;
    bit model_s1_sat   = 1'b0;
    bit model_ovf      = 1'b0;

    always #5 clk = ~clk;

    fir_out_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IN_WIDTH    (IN_WIDTH),
        .SHIFT       (SHIFT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y_in),
        .y_valid  (y_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .sat_flag (sat_flag),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .count    (count)
    );

    // floor((y + HALF) / SCALE) with explicit handling of negative numerators
    function automatic int refRound(input int y);
        int num;
        num = y + HALF;
        if (num >= 0) return num / SCALE;
        return -((-num + SCALE - 1) / SCALE);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_fifo.delete();
        model_s1_valid = 1'b0;
        model_s1_sat   = 1'b0;
        model_ovf      = 1'b0;
    endtask

    task automatic modelEdge(input bit v, input int y, input bit rdy, input bit clr);
        bit do_pop;
        bit dropped;
        int q;
        do_pop  = (model_fifo.size() > 0) && rdy;
        dropped = model_s1_valid && (model_fifo.size() == DEPTH) && !do_pop;
        if (dropped) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        if (do_pop) void'(model_fifo.pop_front());
        if (model_s1_valid && !dropped) model_fifo.push_back(model_s1_val);
        q = refRound(y);
        model_s1_valid = v;
        model_s1_sat   = v && (q > MAX_OUT || q < MIN_OUT);
        model_s1_val   = (q > MAX_OUT) ? MAX_OUT : ((q < MIN_OUT) ? MIN_OUT : q);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " m_valid"}, int'(m_valid), int'(model_fifo.size() > 0));
        checkOutput({tag, " count"}, int'(count), model_fifo.size());
        checkOutput({tag, " overflow"}, int'(overflow), int'(model_ovf));
        checkOutput({tag, " sat_flag"}, int'(sat_flag), int'(model_s1_sat));
        if (model_fifo.size() > 0)
            checkOutput({tag, " m_data"}, int'(m_data), model_fifo[0]);
        else
            checkOutput({tag, " m_data known"}, int'($isunknown(m_data)), 0);
    endtask

    task automatic applyStimulus(input bit v, input int y, input bit rdy, input bit clr, input string tag);
        y_valid = v;
        y_in    = IN_WIDTH'(y);
        m_ready = rdy;
        clr_ovf = clr;
        @(posedge clk);
        modelEdge(v, y, rdy, clr);
        #1;
        checkState(tag);
    endtask

    task automatic resetMidStream(input string tag);
        #2;
        y_valid = 1'b0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        rst     = 1'b0;
        #1;
        modelReset();
        checkState(tag);
        checkOutput({tag, " m_data zero"}, int'(m_data), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int rnd_y;
        logic signed [IN_WIDTH-1:0] wide;
        int round_vals[5] = '{200, 64, 63, -200, -64};
        int sat_vals[6]   = '{20000, -20000, 16255, 16320, -16448, -16449};

        rst = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkState("reset");
        checkOutput("reset m_data zero", int'(m_data), 0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] rounding and saturation");
        foreach (round_vals[i]) applyStimulus(1'b1, round_vals[i], 1'b1, 1'b0, "round");
        foreach (sat_vals[i]) applyStimulus(1'b1, sat_vals[i], 1'b1, 1'b0, "sat");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, "sat tail");

        $display("[TB] fill, overflow and clear");
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 128 * i, 1'b0, 1'b0, "fill");
        applyStimulus(1'b0, 0, 1'b0, 1'b0, "fill tail");
        checkOutput("fill count", int'(count), DEPTH);
        checkOutput("fill overflow", int'(overflow), 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, "clr");
        checkOutput("clr overflow", int'(overflow), 0);
        applyStimulus(1'b1, 128 * 11, 1'b0, 1'b0, "full push");
        applyStimulus(1'b0, 0, 1'b1, 1'b0, "full push+pop");
        checkOutput("push+pop count", int'(count), DEPTH);
        checkOutput("push+pop overflow", int'(overflow), 0);
        applyStimulus(1'b1, 128 * 12, 1'b0, 1'b0, "drop in");
        applyStimulus(1'b0, 0, 1'b0, 1'b1, "drop with clr");
        checkOutput("set beats clr", int'(overflow), 1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, "drain");

        $display("[TB] reset mid-stream");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 256 * i, 1'b0, 1'b0, "prefill");
        applyStimulus(1'b0, 0, 1'b0, 1'b0, "prefill tail");
        checkOutput("prefill count", int'(count), 5);
        resetMidStream("mid reset");
        applyStimulus(1'b1, 384, 1'b0, 1'b0, "post reset 1");
        applyStimulus(1'b0, 0, 1'b0, 1'b0, "post reset 2");
        checkOutput("post reset m_data", int'(m_data), 3);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0: rnd_y = int'($urandom_range(0, 600)) - 300;
                1: begin
                    wide  = IN_WIDTH'($urandom);
                    rnd_y = int'(wide);
                end
                default: rnd_y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16000, 16600))
                                                             : -int'($urandom_range(16000, 16700));
            endcase
            if ($urandom_range(0, 599) == 0) resetMidStream("rand reset");
            applyStimulus($urandom_range(0, 3) != 0, rnd_y,
                          ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 15) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_out_buffer.md
# fir_out_buffer

Output stage for the `fir_filter` result stream, at the read side of the filter. It takes the full-precision signed filter output, rounds and saturates it back to sample width, and buffers it in a small FIFO. A downstream consumer drains the FIFO through a valid/ready handshake. Saturation and overflow are reported as status.

## Interface
- `DATA_WIDTH`, 8, sample width of the drained output (signed)
- `COEFF_WIDTH`, 8, filter coefficient width; only used to derive `IN_WIDTH`
- `IN_WIDTH`, `DATA_WIDTH+COEFF_WIDTH+2`, width of the filter result accepted on `y_in` (signed)
- `SHIFT`, 7, number of fraction bits removed by rounding; must satisfy 1 ≤ SHIFT < IN_WIDTH
- `DEPTH`, 8, FIFO depth in entries; must be a power of two, ≥ 2
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `y_in`  in  IN_WIDTH  signed filter result
- `y_valid`  in  1  `y_in` is a new sample this cycle
- `m_data`  out  DATA_WIDTH  signed sample at the FIFO head
- `m_valid`  out  1  FIFO not empty
- `m_ready`  in  1  consumer accepts `m_data` this cycle
- `sat_flag`  out  1  one-cycle pulse: the sample just registered in stage 1 was clipped
- `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full
- `clr_ovf`  in  1  synchronous clear of `overflow`
- `count`  out  $clog2(DEPTH)+1  number of occupied FIFO entries

## Operation
- Stage 1 (round/saturate) runs on every cycle with `y_valid`=1. It registers the sample, a stage-1 valid bit and `sat_flag`.
- Rounding:
  - Compute t = (y_in + 2^(SHIFT-1)) >>> SHIFT as an arithmetic shift, i.e. round half toward +inf.
  - Compute the add at IN_WIDTH+1 bits so it cannot wrap.
- Saturation:
  - If t > 2^(DATA_WIDTH-1)−1, output 127 (for the default width).
  - If t < −2^(DATA_WIDTH-1), output −128.
  - In both cases `sat_flag`=1 for that cycle.
- Stage 2 (FIFO write) pushes the stage-1 result when the stage-1 valid bit is 1.
- Pop occurs when `m_valid`=1 and `m_ready`=1. `m_data` shows the head entry as first-word-fall-through and stays stable until popped.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets `overflow`=1.
  - A push with a simultaneous pop is accepted; `count` stays unchanged.
- Empty FIFO: `m_ready` is ignored. The `m_data` value is don't-care but must not produce X when `m_valid`=0 after reset.
- Pointers wrap modulo DEPTH.
- `count` changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- `clr_ovf` and a new overflow in the same cycle: `overflow` ends at 1, because set wins.
- No state machine beyond the pipeline valid bit and the FIFO pointers and count.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - stage-1 valid bit, `sat_flag`, `overflow`, pointers and `count` to 0;
  - `m_valid`=0, `m_data`=0;
  - FIFO memory need not be cleared.
- Latency: `y_valid` sampled at edge k → entry written at edge k+1 → `m_valid`=1 after edge k+1 (two cycles) when the FIFO starts empty.
- Throughput: one sample per cycle in, one per cycle out.
- `sat_flag` is high in the cycle after edge k, aligned with the stage-1 register.
- Reset asserted mid-stream:
  - all in-flight and buffered samples are discarded;
  - after release, the first `y_valid` follows the normal latency.

## Structure
- Shared package `fir_pkg` holds:
  - default `DATA_WIDTH`, `COEFF_WIDTH` and `TAPS`;
  - the derived `IN_WIDTH` constant;
  - the rounding/saturation function `fir_round_sat`, so `fir_filter` variants reuse it.
- Sub-module `fir_sync_fifo` is a parameterised single-clock FWFT FIFO with push, pop, full, empty and count.
- `fir_out_buffer` contains the stage-1 register, the flags and one `fir_sync_fifo`.

## Test plan
- Rounding, defaults (SHIFT=7): `y_in` = 200, 64, 63, −200, −64 with `m_ready`=1 → `m_data` = 2, 1, 0, −2, 0, each two cycles after input, with `sat_flag`=0.
- Saturation: `y_in` = 20000 and −20000 → `m_data` = 127 and −128, with a `sat_flag` pulse one cycle after each input.
- Fill and overflow:
  - hold `m_ready`=0 and push 10 samples 128·(1..10) → `count`=8, `overflow`=1;
  - then drain → 1..8 in order, `m_valid` drops after the 8th pop.
- Full with simultaneous push and pop: FIFO full and `y_valid`=1 with `m_ready`=1 in the same cycle → no overflow, `count` stays 8, new sample appears last.
- `clr_ovf`:
  - assert after overflow → `overflow`=0 next cycle;
  - assert in the same cycle as a new drop → `overflow` stays 1.
- Reset mid-stream: pull `rst` low with 5 entries buffered → immediately `m_valid`=0, `count`=0, `overflow`=0; after release, the first sample appears two cycles after input.
